// File: rtl/uart_frame_checker.sv
// UART receive frame checker: checks start, optional parity and stop bits of each frame
// and deserialises the data bits, one sampled bit per bit_valid strobe.
//  state  | meaning
//  IDLE   | waiting for frame_start
//  START  | expecting the start-bit sample (must be 0)
//  DATA   | shifting in DATA_BITS samples, LSB first
//  PARITY | checking the parity sample
//  STOP1  | first stop sample (must be 1)
//  STOP2  | second stop sample (must be 1)
module uart_frame_checker #(
    parameter int DATA_BITS = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 bit_valid,
    input  logic                 sampled_bit,
    input  logic                 par_en,
    input  logic                 par_odd,
    input  logic                 two_stop,
    input  logic                 clr_err_count,
    output logic                 busy,
    output logic                 frame_done,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 start_bit_error,
    output logic                 parity_error,
    output logic                 stop_bit_error,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t               state, state_nxt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 cfg_par_en, cfg_par_odd, cfg_two_stop;
    logic                 par_flag, stop_flag;

    logic latch_cfg, cnt_clr, shift_en, start_abort, finish, par_bad, stop_bad;
    logic frame_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        latch_cfg   = 1'b0;
        cnt_clr     = 1'b0;
        shift_en    = 1'b0;
        start_abort = 1'b0;
        finish      = 1'b0;
        par_bad     = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    latch_cfg = 1'b1;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_valid) begin
                    if (sampled_bit) begin
                        start_abort = 1'b1;
                        state_nxt   = S_IDLE;
                    end else begin
                        cnt_clr   = 1'b1;
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bit_valid) begin
                    shift_en = 1'b1;
                    if (bit_cnt == CNT_W'(DATA_BITS - 1))
                        state_nxt = cfg_par_en ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: begin
                // shift_reg already holds the complete data word here
                if (bit_valid) begin
                    par_bad   = sampled_bit != ((^shift_reg) ^ cfg_par_odd);
                    state_nxt = S_STOP1;
                end
            end
            S_STOP1: begin
                if (bit_valid) begin
                    stop_bad = ~sampled_bit;
                    if (cfg_two_stop) begin
                        state_nxt = S_STOP2;
                    end else begin
                        finish    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_STOP2: begin
                if (bit_valid) begin
                    stop_bad  = ~sampled_bit;
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign frame_err = start_abort | (finish & (par_flag | stop_flag | stop_bad));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg       <= '0;
            bit_cnt         <= '0;
            cfg_par_en      <= 1'b0;
            cfg_par_odd     <= 1'b0;
            cfg_two_stop    <= 1'b0;
            par_flag        <= 1'b0;
            stop_flag       <= 1'b0;
            frame_done      <= 1'b0;
            data_out        <= '0;
            start_bit_error <= 1'b0;
            parity_error    <= 1'b0;
            stop_bit_error  <= 1'b0;
            err_count       <= '0;
        end else begin
            frame_done      <= finish;
            start_bit_error <= start_abort;
            parity_error    <= finish & par_flag;
            stop_bit_error  <= finish & (stop_flag | stop_bad);
            if (finish)
                data_out <= shift_reg;
            if (latch_cfg) begin
                cfg_par_en   <= par_en;
                cfg_par_odd  <= par_odd;
                cfg_two_stop <= two_stop;
                par_flag     <= 1'b0;
                stop_flag    <= 1'b0;
            end
            if (cnt_clr)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + CNT_W'(1);
            if (shift_en)
                shift_reg <= {sampled_bit, shift_reg[DATA_BITS-1:1]};
            if (par_bad)
                par_flag <= 1'b1;
            if (stop_bad)
                stop_flag <= 1'b1;
            // clear takes priority over a same-cycle increment
            if (clr_err_count)
                err_count <= '0;
            else if (frame_err && (err_count != '1))
                err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_frame_checker.sv
// Randomised bench for uart_frame_checker; expected results come from the frame rules
// (parity via popcount, stop levels, saturating error tally) rather than from any FSM model.
module tb_uart_frame_checker;

    localparam int DB = 8;
    localparam int EW = 2;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start, bit_valid, sampled_bit;
    logic          par_en, par_odd, two_stop, clr_err_count;
    logic          busy, frame_done, start_bit_error, parity_error, stop_bit_error;
    logic [DB-1:0] data_out;
    logic [EW-1:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_err = 0;
    logic [DB-1:0] exp_data = '0;

    uart_frame_checker #(.DATA_BITS(DB), .ERR_CNT_W(EW)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .par_en(par_en), .par_odd(par_odd), .two_stop(two_stop),
        .clr_err_count(clr_err_count), .busy(busy), .frame_done(frame_done),
        .data_out(data_out), .start_bit_error(start_bit_error), .parity_error(parity_error),
        .stop_bit_error(stop_bit_error), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tally(input bit err, input bit clr);
        if (clr) exp_err = 0;
        else if (err && exp_err < EMAX) exp_err++;
    endtask

    // idle gap with line noise and stray frame_start pulses, then one valid bit
    task automatic send_bit(input bit b);
        int gap = $urandom_range(0, 3);
        for (int i = 0; i < gap; i++) begin
            sampled_bit = 1'($urandom);
            frame_start = ($urandom_range(0, 5) == 0);
            step();
        end
        frame_start = 1'b0;
        sampled_bit = b;
        bit_valid   = 1'b1;
        step();
        bit_valid   = 1'b0;
    endtask

    task automatic send_frame(input logic [DB-1:0] data, input bit pe, input bit po,
                              input bit ts, input bit start_val, input bit par_flip,
                              input bit stop1, input bit stop2, input bit clr);
        bit p_err, s_err, pbit;
        int gap = $urandom_range(0, 3);
        for (int i = 0; i < gap; i++) begin
            bit_valid   = 1'($urandom);
            sampled_bit = 1'($urandom);
            step();
        end
        frame_start = 1'b1;
        bit_valid   = 1'($urandom);
        sampled_bit = 1'b1;
        par_en = pe; par_odd = po; two_stop = ts;
        step();
        frame_start = 1'b0;
        bit_valid   = 1'b0;
        par_en = 1'($urandom); par_odd = 1'($urandom); two_stop = 1'($urandom);
        chk("busy_after_start", busy, 1);

        if (start_val) begin
            clr_err_count = clr;
            send_bit(1'b1);
            tally(1'b1, clr);
            chk("start_err_pulse", start_bit_error, 1);
            chk("start_no_done", frame_done, 0);
            chk("start_busy", busy, 0);
            chk("start_err_count", err_count, exp_err);
            chk("start_data_held", data_out, exp_data);
            step();
            clr_err_count = 1'b0;
            chk("start_err_single", start_bit_error, 0);
            return;
        end

        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(data[i]);
        chk("busy_mid", busy, 1);
        chk("no_early_done", frame_done, 0);
        p_err = pe && par_flip;
        pbit  = ($countones(data) % 2 == 1) ^ po ^ par_flip;
        if (pe) send_bit(pbit);
        s_err = !stop1 || (ts && !stop2);
        if (ts) begin
            send_bit(stop1);
            clr_err_count = clr;
            send_bit(stop2);
        end else begin
            clr_err_count = clr;
            send_bit(stop1);
        end
        exp_data = data;
        tally(p_err || s_err, clr);
        chk("done_pulse", frame_done, 1);
        chk("data_out", data_out, exp_data);
        chk("parity_error", parity_error, p_err);
        chk("stop_bit_error", stop_bit_error, s_err);
        chk("no_start_err", start_bit_error, 0);
        chk("busy_at_done", busy, 0);
        chk("err_count", err_count, exp_err);
        step();
        clr_err_count = 1'b0;
        chk("done_single", frame_done, 0);
        chk("perr_single", parity_error, 0);
        chk("serr_single", stop_bit_error, 0);
        chk("data_held", data_out, exp_data);
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 0; bit_valid = 0; sampled_bit = 1;
        par_en = 0; par_odd = 0; two_stop = 0; clr_err_count = 0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_data", data_out, 0);
        chk("rst_errcnt", err_count, 0);
        chk("rst_pulses", {start_bit_error, parity_error, stop_bit_error}, 0);
        reset = 1'b0;
        step();

        // data, pe, po, ts, start, par_flip, stop1, stop2, clr
        send_frame(8'hA5, 0, 0, 0, 0, 0, 1, 1, 0);   // 8N1 clean
        send_frame(8'h00, 0, 0, 0, 1, 0, 1, 1, 0);   // start abort -> 1
        send_frame(8'h07, 1, 0, 0, 0, 1, 1, 1, 0);   // 8E1 parity bit 0 -> error, 2
        send_frame(8'h07, 1, 0, 0, 0, 0, 1, 1, 0);   // 8E1 parity bit 1 clean
        send_frame(8'h07, 1, 1, 0, 0, 0, 1, 1, 0);   // 8O1 parity bit 0 clean
        send_frame(8'h5A, 0, 0, 1, 0, 0, 1, 0, 0);   // 8N2 bad 2nd stop -> 3
        send_frame(8'h11, 0, 0, 0, 1, 0, 1, 1, 0);   // 4th errored, saturated
        send_frame(8'h22, 0, 0, 0, 0, 0, 0, 1, 0);   // 5th errored, saturated
        chk("saturated", err_count, EMAX);
        send_frame(8'h33, 1, 1, 1, 0, 1, 1, 1, 1);   // 6th errored with clear -> 0

        // reset after the 4th data bit
        frame_start = 1'b1; step(); frame_start = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        #2 reset = 1'b1;
        #1;
        exp_err = 0; exp_data = '0;
        chk("midrst_busy", busy, 0);
        chk("midrst_data", data_out, 0);
        chk("midrst_errcnt", err_count, 0);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_done", frame_done, 0);
        send_frame(8'h3C, 0, 0, 0, 0, 0, 1, 1, 0);

        for (int f = 0; f < 40; f++) begin
            bit pe = 1'($urandom);
            send_frame(8'($urandom), pe, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 9) == 0), pe && ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                       ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
